// File: rtl/dmem_responder.sv
// Data-memory responder: word array behind a posted store buffer with store-to-load bypass,
// plus a valid/ready host port. Optional address bounds checking under DMEM_BOUNDS_CHECK_EN.
module dmem_responder #(
    parameter int unsigned WORDS    = 1024,
    parameter int unsigned SB_DEPTH = 4
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [15:0]               MemAddr,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [31:0]               WriteData,
    output logic [31:0]               MemData,
    input  logic                      HostValid,
    output logic                      HostReady,
    input  logic                      HostWrite,
    input  logic [15:0]               HostAddr,
    input  logic [31:0]               HostWData,
    output logic [31:0]               HostRData,
    output logic                      HostRValid,
    output logic [$clog2(SB_DEPTH):0] SbCount,
    output logic                      AddrErr
);

    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      mem [WORDS];
    logic [IDX_W-1:0] sbIdx [SB_DEPTH];
    logic [31:0]      sbData [SB_DEPTH];
    logic [SB_DEPTH-1:0] sbValid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [IDX_W-1:0] memIdx;
    logic [IDX_W-1:0] hostIdx;
    logic             memInRange;
    logic             hostInRange;
    logic             enq;
    logic             drain;
    logic             hostAcc;
    logic             bypassHit;
    logic [31:0]      bypassData;
    logic [PTR_W-1:0] pos;

    // Address bits outside the word index are intentionally ignored.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{MemAddr, HostAddr};

    assign memIdx  = MemAddr[IDX_W+1:2];
    assign hostIdx = HostAddr[IDX_W+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [14:0] WORD_LIMIT = 15'(WORDS);
    assign memInRange  = ({1'b0, MemAddr[15:2]} < WORD_LIMIT);
    assign hostInRange = ({1'b0, HostAddr[15:2]} < WORD_LIMIT);
`else
    assign memInRange  = 1'b1;
    assign hostInRange = 1'b1;
`endif

    assign enq       = MemWrite & memInRange;
    assign drain     = (count != '0);
    assign HostReady = (count == '0);
    assign hostAcc   = HostValid & HostReady & ~Reset;
    assign SbCount   = count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            sbValid <= '0;
        end else begin
            if (drain) begin
                sbValid[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            if (enq) begin
                sbValid[tail] <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(drain);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && enq) begin
            sbIdx[tail]  <= memIdx;
            sbData[tail] <= WriteData;
        end
    end

    // Host is only accepted with an empty buffer, so drain and host writes never collide.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (drain) begin
                mem[sbIdx[head]] <= sbData[head];
            end else if (hostAcc && HostWrite && hostInRange) begin
                mem[hostIdx] <= HostWData;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            HostRValid <= 1'b0;
            HostRData  <= '0;
        end else begin
            HostRValid <= hostAcc & ~HostWrite;
            if (hostAcc && !HostWrite) begin
                HostRData <= hostInRange ? mem[hostIdx] : 32'h0;
            end
        end
    end

    // Walk oldest to newest so the last match is the newest store.
    always_comb begin
        bypassHit  = 1'b0;
        bypassData = '0;
        pos        = head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            pos = head + PTR_W'(i);
            if (sbValid[pos] && (sbIdx[pos] == memIdx)) begin
                bypassHit  = 1'b1;
                bypassData = sbData[pos];
            end
        end
    end

    always_comb begin
        MemData = '0;
        if (MemRead && memInRange) begin
            MemData = bypassHit ? bypassData : mem[memIdx];
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            AddrErr <= 1'b0;
        end else if (((MemRead || MemWrite) && !memInRange) || (hostAcc && !hostInRange)) begin
            AddrErr <= 1'b1;
        end
    end
`else
    assign AddrErr = 1'b0;
`endif

    assert property (@(posedge Clock) disable iff (Reset) count <= CNT_W'(SB_DEPTH));

endmodule
